dp_ram_arbiter: RTL and testbench

//  Shares one 64x8 dual-port RAM (dp_ram) between NREQ requesters.
//  The write port and the read port are arbitrated independently, each with its own round-robin pointer.

---
 rtl/dp_ram_pkg.sv | 22 ++
 rtl/dp_ram_arbiter_rr_arbiter.sv | 67 ++++++
 rtl/dp_ram_arbiter.sv | 94 +++++++++
 tb/tb_dp_ram_arbiter.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/dp_ram_pkg.sv
// Shared constants for the dual-port RAM and its requester arbiter.
//   AW        RAM address width
//   DW        RAM data width
//   NREQ_DEF  default number of requesters
//   RAM_DEPTH words in the dual-port RAM
//   rr_next() round-robin successor of an index, wrapping at n
package dp_ram_pkg;

  localparam int AW        = 6;
  localparam int DW        = 8;
  localparam int NREQ_DEF  = 4;
  localparam int RAM_DEPTH = 2 ** AW;

  function automatic int rr_next(input int idx, input int n);
    if (idx + 1 >= n) begin
      return 0;
    end else begin
      return idx + 1;
    end
  endfunction

endpackage

// File: rtl/dp_ram_arbiter_rr_arbiter.sv
// Round-robin arbiter with a registered search pointer.
//   clk   in   clock, rising edge
//   rst   in   synchronous, active-low reset (pointer to 0, grant forced 0)
//   req   in   NREQ request vector
//   gnt   out  NREQ one-hot/zero grant, combinational from req and pointer
// The first requester at or after the pointer (searching upward, modulo
// NREQ) wins; the pointer then moves one past the winner, or holds when
// nothing is granted.
module rr_arbiter
  import dp_ram_pkg::*;
#(
  parameter int NREQ = NREQ_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] gnt
);

  localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

  logic [PW-1:0] ptr_q;
  logic [PW-1:0] ptr_d;
  logic [PW-1:0] idx_b;
  logic          found;
  int            idx;

  // Grant search starting at the pointer and next-pointer selection.
  always_comb begin
    gnt   = {NREQ{1'b0}};
    ptr_d = ptr_q;
    found = 1'b0;
    idx   = 0;
    idx_b = {PW{1'b0}};
    if (rst) begin
      for (int k = 0; k < NREQ; k++) begin
        idx = int'(ptr_q) + k;
        if (idx >= NREQ) begin
          idx = idx - NREQ;
        end else begin
          idx = idx;
        end
        idx_b = PW'(idx);
        if (!found && req[idx_b]) begin
          found      = 1'b1;
          gnt[idx_b] = 1'b1;
          ptr_d      = PW'(rr_next(idx, NREQ));
        end else begin
          found = found;
        end
      end
    end else begin
      // Held in reset: no grants, pointer heads back to 0.
      ptr_d = {PW{1'b0}};
    end
  end

  // Round-robin pointer register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr_q <= {PW{1'b0}};
    end else begin
      ptr_q <= ptr_d;
    end
  end

endmodule

// File: rtl/dp_ram_arbiter.sv
// Shares one dual-port RAM between NREQ requesters. Write and read ports are
// arbitrated independently by two round-robin arbiters.
//   clk, rst               clock (rising edge), sync active-low reset
//   req_wr / req_rd        per-requester requests, held until granted
//   wr_addr_in/wr_data_in  packed write address/data, requester i at slice i
//   rd_addr_in             packed read addresses, requester i at slice i
//   wr_gnt / rd_gnt        one-hot/zero grants, combinational
//   rd_valid               one-hot/zero owner of rd_data_out, cycle after grant
//   rd_data_out            RAM read data, broadcast to every requester
//   ram_*                  RAM pin drive (enable/wr/rd/addresses/data in+out)
module dp_ram_arbiter
  import dp_ram_pkg::*;
#(
  parameter int NREQ = NREQ_DEF,
  parameter int AW   = dp_ram_pkg::AW,
  parameter int DW   = dp_ram_pkg::DW
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [NREQ-1:0]  req_wr,
  input  logic [NREQ-1:0]  req_rd,
  input  logic [NREQ*AW-1:0] wr_addr_in,
  input  logic [NREQ*DW-1:0] wr_data_in,
  input  logic [NREQ*AW-1:0] rd_addr_in,
  output logic [NREQ-1:0]  wr_gnt,
  output logic [NREQ-1:0]  rd_gnt,
  output logic [NREQ-1:0]  rd_valid,
  output logic [DW-1:0]    rd_data_out,
  output logic             ram_enable,
  output logic             ram_wr,
  output logic             ram_rd,
  output logic [AW-1:0]    ram_wr_addr,
  output logic [AW-1:0]    ram_rd_addr,
  output logic [DW-1:0]    ram_wr_data,
  input  logic [DW-1:0]    ram_rd_data
);

  logic [NREQ-1:0] rd_pend_q;
  logic [NREQ-1:0] rd_pend_d;

  rr_arbiter #(.NREQ(NREQ)) u_wr_arb (
    .clk (clk),
    .rst (rst),
    .req (req_wr),
    .gnt (wr_gnt)
  );

  rr_arbiter #(.NREQ(NREQ)) u_rd_arb (
    .clk (clk),
    .rst (rst),
    .req (req_rd),
    .gnt (rd_gnt)
  );

  // AND-OR muxes keyed by the one-hot grants; all-zero grant gives zero pins.
  always_comb begin
    ram_wr_addr = {AW{1'b0}};
    ram_wr_data = {DW{1'b0}};
    ram_rd_addr = {AW{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      ram_wr_addr = ram_wr_addr | (wr_addr_in[i*AW +: AW] & {AW{wr_gnt[i]}});
      ram_wr_data = ram_wr_data | (wr_data_in[i*DW +: DW] & {DW{wr_gnt[i]}});
      ram_rd_addr = ram_rd_addr | (rd_addr_in[i*AW +: AW] & {AW{rd_gnt[i]}});
    end
  end

  assign ram_wr     = |wr_gnt;
  assign ram_rd     = |rd_gnt;
  assign ram_enable = ram_wr | ram_rd;

  // The RAM registers its read data, so the owner tag trails the grant by one.
  assign rd_pend_d   = rd_gnt;
  assign rd_data_out = ram_rd_data;

  // Read-owner pipeline register.
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_pend_q <= {NREQ{1'b0}};
    end else begin
      rd_pend_q <= rd_pend_d;
    end
  end

  // A read granted just before reset is pending when reset lands; masking
  // here keeps it from ever surfacing as rd_valid.
  always_comb begin
    if (rst) begin
      rd_valid = rd_pend_q;
    end else begin
      rd_valid = {NREQ{1'b0}};
    end
  end

endmodule

// File: tb/tb_dp_ram_arbiter.sv
module tb_dp_ram_arbiter;

  localparam int NREQ = 4;
  localparam int AW   = 6;
  localparam int DW   = 8;

  logic               clk = 1'b0;
  logic               rst;
  logic [NREQ-1:0]    req_wr;
  logic [NREQ-1:0]    req_rd;
  logic [NREQ*AW-1:0] wr_addr_in;
  logic [NREQ*DW-1:0] wr_data_in;
  logic [NREQ*AW-1:0] rd_addr_in;
  logic [NREQ-1:0]    wr_gnt;
  logic [NREQ-1:0]    rd_gnt;
  logic [NREQ-1:0]    rd_valid;
  logic [DW-1:0]      rd_data_out;
  logic               ram_enable;
  logic               ram_wr;
  logic               ram_rd;
  logic [AW-1:0]      ram_wr_addr;
  logic [AW-1:0]      ram_rd_addr;
  logic [DW-1:0]      ram_wr_data;
  logic [DW-1:0]      ram_rd_data;

  logic [DW-1:0] mem [0:63];

  int n_assert = 0;
  int n_fail   = 0;

  logic [3:0] rr_exp [5];

  always #5 clk = ~clk;

  dp_ram_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_wr      (req_wr),
    .req_rd      (req_rd),
    .wr_addr_in  (wr_addr_in),
    .wr_data_in  (wr_data_in),
    .rd_addr_in  (rd_addr_in),
    .wr_gnt      (wr_gnt),
    .rd_gnt      (rd_gnt),
    .rd_valid    (rd_valid),
    .rd_data_out (rd_data_out),
    .ram_enable  (ram_enable),
    .ram_wr      (ram_wr),
    .ram_rd      (ram_rd),
    .ram_wr_addr (ram_wr_addr),
    .ram_rd_addr (ram_rd_addr),
    .ram_wr_data (ram_wr_data),
    .ram_rd_data (ram_rd_data)
  );

  // Behavioural dp_ram: registered read, nonblocking write (read sees old word).
  always @(posedge clk) begin
    if (ram_enable && ram_wr) mem[ram_wr_addr] <= ram_wr_data;
    if (ram_enable && ram_rd) ram_rd_data <= mem[ram_rd_addr];
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    @(negedge clk);
  endtask

  initial begin
    rr_exp[0] = 4'b0001; rr_exp[1] = 4'b0010; rr_exp[2] = 4'b0100;
    rr_exp[3] = 4'b1000; rr_exp[4] = 4'b0001;

    // 1: reset with every request asserted
    rst = 1'b0; req_wr = 4'hF; req_rd = 4'hF;
    wr_addr_in = '0; wr_data_in = '0; rd_addr_in = '0;
    settle();
    chk("rst_wr_gnt", {28'd0, wr_gnt}, 32'h0);
    chk("rst_rd_gnt", {28'd0, rd_gnt}, 32'h0);
    chk("rst_ram_enable", {31'd0, ram_enable}, 32'h0);
    chk("rst_rd_valid", {28'd0, rd_valid}, 32'h0);
    tick();
    settle();
    chk("rst2_wr_gnt", {28'd0, wr_gnt}, 32'h0);
    chk("rst2_rd_valid", {28'd0, rd_valid}, 32'h0);
    tick();

    // idle after reset release
    rst = 1'b1; req_wr = 4'h0; req_rd = 4'h0;
    for (int i = 0; i < NREQ; i++) begin
      wr_addr_in[i*AW +: AW] = 6'd60 + 6'(i);
      wr_data_in[i*DW +: DW] = 8'hC0 + 8'(i);
    end
    settle();
    chk("idle_wr_gnt", {28'd0, wr_gnt}, 32'h0);
    chk("idle_ram_enable", {31'd0, ram_enable}, 32'h0);
    tick();
    settle();
    chk("idle_rd_valid", {28'd0, rd_valid}, 32'h0);
    tick();

    // 3: round robin with all writers requesting
    req_wr = 4'hF;
    for (int k = 0; k < 5; k++) begin
      settle();
      chk("rr_wr_gnt", {28'd0, wr_gnt}, {28'd0, rr_exp[k]});
      tick();
    end

    // 4: wr_ptr=1, only requester 0 -> wrap search, pointer back to 1
    req_wr = 4'b0001;
    settle();
    chk("sparse_wr_gnt", {28'd0, wr_gnt}, 32'h1);
    tick();
    req_wr = 4'hF;
    settle();
    chk("sparse_ptr_wr_gnt", {28'd0, wr_gnt}, 32'h2);
    tick();

    // 2: write 8'hA5 to 5, then read it back (wr_ptr=2, rd_ptr=0)
    req_wr = 4'b0100; wr_addr_in[2*AW +: AW] = 6'd5; wr_data_in[2*DW +: DW] = 8'hA5;
    settle();
    chk("w_wr_gnt", {28'd0, wr_gnt}, 32'h4);
    chk("w_ram_wr", {31'd0, ram_wr}, 32'h1);
    chk("w_ram_wr_addr", {26'd0, ram_wr_addr}, 32'h5);
    chk("w_ram_wr_data", {24'd0, ram_wr_data}, 32'hA5);
    chk("w_ram_enable", {31'd0, ram_enable}, 32'h1);
    tick();
    req_wr = 4'h0; req_rd = 4'b0010; rd_addr_in[1*AW +: AW] = 6'd5;
    settle();
    chk("r_rd_gnt", {28'd0, rd_gnt}, 32'h2);
    chk("r_ram_rd", {31'd0, ram_rd}, 32'h1);
    chk("r_ram_rd_addr", {26'd0, ram_rd_addr}, 32'h5);
    chk("r_ram_wr", {31'd0, ram_wr}, 32'h0);
    tick();
    req_rd = 4'h0;
    settle();
    chk("r_rd_valid", {28'd0, rd_valid}, 32'h2);
    chk("r_rd_data", {24'd0, rd_data_out}, 32'hA5);
    tick();

    // 5: mem[9]=11 (wr_ptr=3 wraps to 0), then write 22 and read 9 together
    req_wr = 4'b0001; wr_addr_in[0 +: AW] = 6'd9; wr_data_in[0 +: DW] = 8'h11;
    settle();
    chk("pre_wr_gnt", {28'd0, wr_gnt}, 32'h1);
    tick();
    wr_data_in[0 +: DW] = 8'h22; req_rd = 4'b1000; rd_addr_in[3*AW +: AW] = 6'd9;
    settle();
    chk("sim_wr_gnt", {28'd0, wr_gnt}, 32'h1);
    chk("sim_rd_gnt", {28'd0, rd_gnt}, 32'h8);
    tick();
    req_wr = 4'h0; req_rd = 4'b0001; rd_addr_in[0 +: AW] = 6'd9;
    settle();
    chk("sim_rd_valid", {28'd0, rd_valid}, 32'h8);
    chk("sim_old_data", {24'd0, rd_data_out}, 32'h11);
    chk("b2b_rd_gnt", {28'd0, rd_gnt}, 32'h1);
    tick();
    req_rd = 4'h0;
    settle();
    chk("b2b_rd_valid", {28'd0, rd_valid}, 32'h1);
    chk("b2b_new_data", {24'd0, rd_data_out}, 32'h22);
    tick();

    // 6: read granted (rd_ptr=1 -> 1000), reset the next cycle
    req_rd = 4'b1000;
    settle();
    chk("mid_rd_gnt", {28'd0, rd_gnt}, 32'h8);
    tick();
    rst = 1'b0; req_rd = 4'h0;
    settle();
    chk("mid_rd_valid0", {28'd0, rd_valid}, 32'h0);
    tick();
    settle();
    chk("mid_rd_valid1", {28'd0, rd_valid}, 32'h0);
    tick();
    rst = 1'b1;
    settle();
    chk("mid_rd_valid2", {28'd0, rd_valid}, 32'h0);
    tick();
    // wr_ptr was 1 before reset; both pointers must restart at 0
    req_wr = 4'hF; req_rd = 4'hF;
    settle();
    chk("post_rst_wr_gnt", {28'd0, wr_gnt}, 32'h1);
    chk("post_rst_rd_gnt", {28'd0, rd_gnt}, 32'h1);
    tick();
    req_wr = 4'h0; req_rd = 4'h0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
